controle_operacao_memoria: RTL

Multi-cycle control unit that sequences the shared add/sub + address datapath (operand muxes feeding one adder/subtractor) for the 64-bit processor. Accepts one instruction at a time over a valid/ready handshake, decodes ADD/SUB/LD/SD, and drives the datapath selects. It also drives the register-file read/write addresses and write enable, and the data-memory request/ack handshake.

---
 rtl/controle_operacao_memoria_pkg.sv | 33 +++
 rtl/controle_operacao_memoria_if.sv | 36 +++
 rtl/controle_operacao_memoria_decodificador_instr.sv | 47 ++++
 rtl/controle_operacao_memoria.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/controle_operacao_memoria_pkg.sv
// Shared constants and types for the memory-operation control unit.
package controle_operacao_memoria_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_D      = 3'b011;
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StDone   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_LD  = 3'd2,
        OP_SD  = 3'd3,
        OP_ILL = 3'd4
    } op_e;

    function automatic logic is_mem_op(op_e op);
        return (op == OP_LD) || (op == OP_SD);
    endfunction

endpackage

// File: rtl/controle_operacao_memoria_if.sv
// Instruction, register-file, datapath-select and memory signals of the controller.
// master = controller side, slave = surrounding datapath/memory/issue side.
interface controle_operacao_memoria_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic [REG_AW-1:0] rf_ra;
    logic [REG_AW-1:0] rf_rb;
    logic [REG_AW-1:0] rf_wa;
    logic              rf_we;
    logic              wb_sel;
    logic [DATA_W-1:0] OFFSET;
    logic              OP_MEM;
    logic              ADD_SUB;
    logic              mem_re;
    logic              mem_we;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  instr_valid, instr, mem_ack,
        output instr_ready, rf_ra, rf_rb, rf_wa, rf_we, wb_sel, OFFSET, OP_MEM, ADD_SUB,
        output mem_re, mem_we, busy, done, err
    );

    modport slave (
        output instr_valid, instr, mem_ack,
        input  instr_ready, rf_ra, rf_rb, rf_wa, rf_we, wb_sel, OFFSET, OP_MEM, ADD_SUB,
        input  mem_re, mem_we, busy, done, err
    );
endinterface

// File: rtl/controle_operacao_memoria_decodificador_instr.sv
// Purely combinational decode of ADD/SUB/LD/SD, register fields and sign-extended offset.
module decodificador_instr
    import controle_operacao_memoria_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic [31:0]       instr_i,
    output op_e               op_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [DATA_W-1:0] offset_o
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1_o  = REG_AW'(instr_i[19:15]);
    assign rs2_o  = REG_AW'(instr_i[24:20]);
    assign rd_o   = REG_AW'(instr_i[11:7]);

    // Classify the word and select the immediate format it carries.
    always_comb begin
        op_o = OP_ILL;
        imm  = 12'h000;
        if (opcode == OPC_RTYPE && funct3 == F3_ADDSUB) begin
            if (funct7 == F7_ADD) begin
                op_o = OP_ADD;
            end else if (funct7 == F7_SUB) begin
                op_o = OP_SUB;
            end
        end else if (opcode == OPC_LOAD && funct3 == F3_D) begin
            op_o = OP_LD;
            imm  = instr_i[31:20];
        end else if (opcode == OPC_STORE && funct3 == F3_D) begin
            op_o = OP_SD;
            imm  = {instr_i[31:25], instr_i[11:7]};
        end
    end

    assign offset_o = {{(DATA_W-12){imm[11]}}, imm};
endmodule

// File: rtl/controle_operacao_memoria.sv
// Multi-cycle controller for the shared add/sub + address datapath.
// Optional macro MEM_TIMEOUT_EN: abort a memory access after MEM_TIMEOUT cycles without ack.
module controle_operacao_memoria
    import controle_operacao_memoria_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned MEM_TIMEOUT = 16
`endif
) (
    input logic                          clk,
    input logic                          reset,
    controle_operacao_memoria_if.master  bus
);
    op_e               dec_op;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [DATA_W-1:0] dec_offset;

    state_e            state_q, state_d;
    op_e               op_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_W-1:0] offset_q;
    logic              err_q, err_d;
    logic              accept;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]        wait_q, wait_d;
`endif

    decodificador_instr #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_dec (
        .instr_i  (bus.instr),
        .op_o     (dec_op),
        .rs1_o    (dec_rs1),
        .rs2_o    (dec_rs2),
        .rd_o     (dec_rd),
        .offset_o (dec_offset)
    );

    assign accept = (state_q == StIdle) && bus.instr_valid;

    // State register plus abort flag (and wait counter when enabled).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    // Capture the decoded instruction on accept; held until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_ILL;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            offset_q <= '0;
        end else if (accept) begin
            op_q     <= dec_op;
            rs1_q    <= dec_rs1;
            rs2_q    <= dec_rs2;
            rd_q     <= dec_rd;
            offset_q <= dec_offset;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
`ifdef MEM_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StDecode;
                    err_d   = 1'b0;
                end
            end
            StDecode: begin
                if (op_q == OP_ILL) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_mem_op(op_q)) begin
                    state_d = StMem;
`ifdef MEM_TIMEOUT_EN
                    wait_d  = 8'd0;
`endif
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (bus.mem_ack) begin
                    state_d = (op_q == OP_LD) ? StWb : StDone;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_q == 8'(MEM_TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            StWb:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: selects held from DECODE through DONE, strobes decoded from state.
    always_comb begin
        bus.instr_ready = (state_q == StIdle);
        bus.busy        = (state_q != StIdle);
        bus.rf_ra       = '0;
        bus.rf_rb       = '0;
        bus.OFFSET      = '0;
        bus.OP_MEM      = 1'b0;
        bus.ADD_SUB     = 1'b0;
        if (state_q != StIdle) begin
            unique case (op_q)
                OP_ADD, OP_SUB: begin
                    bus.rf_ra   = rs1_q;
                    bus.rf_rb   = rs2_q;
                    bus.ADD_SUB = (op_q == OP_SUB);
                end
                OP_LD, OP_SD: begin
                    bus.rf_ra  = rs2_q;
                    bus.rf_rb  = rs1_q;
                    bus.OFFSET = offset_q;
                    bus.OP_MEM = 1'b1;
                end
                default: ;
            endcase
        end
        bus.mem_re = (state_q == StMem) && (op_q == OP_LD);
        bus.mem_we = (state_q == StMem) && (op_q == OP_SD);
        bus.rf_we  = (state_q == StWb) && (rd_q != '0);
        bus.rf_wa  = (state_q == StWb) ? rd_q : '0;
        bus.wb_sel = (state_q == StWb) && (op_q == OP_LD);
        bus.done   = (state_q == StDone);
        bus.err    = (state_q == StDone) && err_q;
    end
endmodule
